// File: rtl/data_sram_access_pkg.sv
// Shared widths, access-size codes and MEM-stage FSM states for data_sram_access.
package data_sram_access_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_WAIT = 2'b01,
    MS_DONE = 2'b10
  } ms_state_e;

endpackage

// File: rtl/data_sram_access_if.sv
// sram-like data bus: req/addr_ok/data_ok handshake with one outstanding access.
interface data_sram_access_if;
  import data_sram_access_pkg::*;

  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [XLEN-1:0] data_addr;
  logic [XLEN-1:0] data_wdata;
  logic [XLEN-1:0] data_rdata;
  logic            data_addr_ok;
  logic            data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );

endinterface

// File: rtl/data_sram_access_load_store_align.sv
// Combinational store lane replication, load lane extraction/extension and
// alignment check for byte, halfword and word accesses.
module load_store_align
  import data_sram_access_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rbuf,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rbuf >> {addr, 3'b000});
  assign half_sel = addr[1] ? rbuf[31:16] : rbuf[15:0];

  // Size code 11 behaves as a word access.
  always_comb begin
    wdata      = store_data;
    load_data  = rbuf;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      MEM_HALF: begin
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{sign & half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      MEM_WORD: misaligned = |addr;
      default:  misaligned = |addr;
    endcase
  end

endmodule

// File: rtl/data_sram_access.sv
// MIPS MEM stage: drives the sram-like data bus, stalls upstream until the
// access completes, and holds the MEM->WB pipeline register.
module data_sram_access
  import data_sram_access_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [1:0]       ex_mem_size,
  input  logic             ex_mem_sign,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic             ex_reg_write,
  input  logic [REGW-1:0]  ex_write_reg,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_inst,
  data_sram_access_if.master bus,
  output logic             mem_stall,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [REGW-1:0]  wb_write_reg,
  output logic [XLEN-1:0]  wb_result,
  output logic [XLEN-1:0]  wb_pc,
  output logic [XLEN-1:0]  wb_inst,
  output logic             wb_addr_err
);

  ms_state_e       state;
  logic [XLEN-1:0] rbuf;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] load_data;
  logic            misaligned;
  logic            mem_access;
  logic            mem_op;
  logic            is_load;

  load_store_align u_align (
    .size       (ex_mem_size),
    .sign       (ex_mem_sign),
    .addr       (ex_result[1:0]),
    .store_data (ex_store_data),
    .rbuf       (rbuf),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign mem_access = ex_valid & (ex_mem_read | ex_mem_write);
  assign mem_op     = mem_access & ~misaligned;
  assign is_load    = ex_valid & ex_mem_read & ~misaligned;
  assign mem_stall  = mem_op & (state != MS_DONE);

  // Request drops at once under reset even while the upstream still shows a memory op.
  assign bus.data_req   = rstn & mem_op & (state == MS_IDLE);
  assign bus.data_wr    = ex_mem_write;
  assign bus.data_size  = ex_mem_size;
  assign bus.data_addr  = ex_result;
  assign bus.data_wdata = wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= MS_IDLE;
      rbuf         <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_write_reg <= '0;
      wb_result    <= '0;
      wb_pc        <= '0;
      wb_inst      <= '0;
      wb_addr_err  <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: if (mem_op & bus.data_addr_ok) state <= MS_WAIT;
        MS_WAIT: begin
          if (bus.data_data_ok) begin
            rbuf  <= bus.data_rdata;
            state <= MS_DONE;
          end
        end
        MS_DONE: state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase

      // Stalled cycles insert a bubble; payload fields keep their last value.
      if (mem_stall) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end else begin
        wb_valid     <= ex_valid;
        wb_reg_write <= ex_reg_write & ex_valid & ~misaligned;
        wb_write_reg <= ex_write_reg;
        wb_result    <= is_load ? load_data : ex_result;
        wb_pc        <= ex_pc;
        wb_inst      <= ex_inst;
        wb_addr_err  <= mem_access & misaligned;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_access.sv
// Randomized bench for data_sram_access against a transaction-level model.
module tb_data_sram_access;

  logic        clk;
  logic        rstn;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_sign, ex_reg_write;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_result, ex_store_data, ex_pc, ex_inst;
  logic [4:0]  ex_write_reg;
  logic        mem_stall, wb_valid, wb_reg_write, wb_addr_err;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_result, wb_pc, wb_inst;

  int n_checks = 0;
  int n_fail   = 0;

  data_sram_access_if bus ();

  data_sram_access dut (
    .clk           (clk),
    .rstn          (rstn),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_size   (ex_mem_size),
    .ex_mem_sign   (ex_mem_sign),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_reg_write  (ex_reg_write),
    .ex_write_reg  (ex_write_reg),
    .ex_pc         (ex_pc),
    .ex_inst       (ex_inst),
    .bus           (bus),
    .mem_stall     (mem_stall),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_result     (wb_result),
    .wb_pc         (wb_pc),
    .wb_inst       (wb_inst),
    .wb_addr_err   (wb_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] sd);
    longint v;
    case (nbytes(size))
      1:       v = longint'(sd % 256) * 64'h01010101;
      2:       v = longint'(sd % 65536) * 64'h00010001;
      default: v = longint'(sd);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                           input logic [31:0] addr, input logic [31:0] rd);
    int     n;
    longint lane, val, span;
    n = nbytes(size);
    if (n == 4) return rd;
    lane = longint'((addr % 4) / n) * n * 8;
    span = 64'd1 << (8 * n);
    val  = (longint'(rd) >> lane) % span;
    if (sign && val >= span / 2) val = val - span;
    return 32'(val);
  endfunction

  // One instruction through MEM; the bench acts as bus slave with aw addr_ok
  // wait cycles and dw data_ok wait cycles, optionally injecting stray data_ok.
  task automatic issue(input logic v, input logic rd, input logic wr, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rdata, input logic rw, input logic [4:0] wreg,
                       input int aw, input int dw, input bit stray);
    logic [31:0] pc, inst, exp_res;
    bit          mis, memop, done;
    int          req_n, stall_n, wb_n, n_cyc, acc_cyc;
    pc = $urandom; inst = $urandom;
    mis   = ref_misaligned(size, addr);
    memop = v && (rd || wr) && !mis;
    exp_res = (v && rd && !mis) ? ref_load(size, sign, addr, rdata) : addr;
    req_n = 0; stall_n = 0; wb_n = 0; n_cyc = 0; acc_cyc = -1; done = 0;
    @(negedge clk);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = size;
    ex_mem_sign = sign; ex_result = addr; ex_store_data = sd; ex_reg_write = rw;
    ex_write_reg = wreg; ex_pc = pc; ex_inst = inst;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
      #1;
      n_cyc++;
      if (cyc > 0 && wb_valid) wb_n++;
      if (bus.data_req) begin
        req_n++;
        if (req_n == 1) begin
          check("req_addr", bus.data_addr, addr);
          check("req_wr", 32'(bus.data_wr), 32'(wr));
          check("req_size", 32'(bus.data_size), 32'(size));
          if (wr) check("req_wdata", bus.data_wdata, ref_wdata(size, sd));
        end
        if (req_n == aw + 1) begin
          bus.data_addr_ok = 1'b1;
          acc_cyc = cyc;
        end else if (stray) bus.data_data_ok = 1'b1;
      end
      if (acc_cyc >= 0 && cyc == acc_cyc + 1 + dw) begin
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rdata;
      end
      if (stray && acc_cyc >= 0 && cyc == acc_cyc + 2 + dw) bus.data_data_ok = 1'b1;
      if (mem_stall) stall_n++;
      else done = 1;
    end
    if (!done) begin
      check("mem_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    ex_valid = 1'b0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    #1;
    if (wb_valid) wb_n++;
    check("req_cycles", 32'(req_n), memop ? 32'(aw + 1) : 32'd0);
    check("stall_cycles", 32'(stall_n), memop ? 32'(aw + dw + 2) : 32'd0);
    check("mem_cycles", 32'(n_cyc), memop ? 32'(aw + dw + 3) : 32'd1);
    check("wb_count", 32'(wb_n), v ? 32'd1 : 32'd0);
    check("wb_valid", 32'(wb_valid), 32'(v));
    check("wb_reg_write", 32'(wb_reg_write), 32'(v && rw && !mis));
    check("wb_addr_err", 32'(wb_addr_err), 32'(v && (rd || wr) && mis));
    check("wb_write_reg", 32'(wb_write_reg), 32'(wreg));
    check("wb_pc", wb_pc, pc);
    check("wb_inst", wb_inst, inst);
    if (!mis) check("wb_result", wb_result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          op;
    rstn = 1'b0;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = 0; ex_mem_sign = 0;
    ex_result = 0; ex_store_data = 0; ex_reg_write = 0; ex_write_reg = 0; ex_pc = 0; ex_inst = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    #12;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_req", 32'(bus.data_req), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Directed cases
    issue(1, 0, 0, 2'd2, 0, 32'h0000_1234, 0, 0, 1, 5'd5, 0, 0, 0);
    check("nonmem_result", wb_result, 32'h0000_1234);
    issue(1, 1, 0, 2'd2, 0, 32'h0000_0100, 0, 32'hDEADBEEF, 1, 5'd8, 2, 0, 0);
    check("lw_result", wb_result, 32'hDEADBEEF);
    issue(1, 1, 0, 2'd0, 1, 32'h0000_0203, 0, 32'h80FF7F01, 1, 5'd9, 0, 0, 0);
    check("lb_result", wb_result, 32'hFFFFFF80);
    issue(1, 1, 0, 2'd0, 0, 32'h0000_0203, 0, 32'h80FF7F01, 1, 5'd9, 1, 1, 0);
    check("lbu_result", wb_result, 32'h00000080);
    issue(1, 1, 0, 2'd1, 1, 32'h0000_0200, 0, 32'h80FF7F01, 1, 5'd10, 0, 2, 1);
    check("lh_result", wb_result, 32'h00007F01);
    issue(1, 1, 0, 2'd1, 0, 32'h0000_0202, 0, 32'h80FF7F01, 1, 5'd11, 0, 0, 0);
    check("lhu_result", wb_result, 32'h000080FF);
    issue(1, 0, 1, 2'd0, 0, 32'h0000_0202, 32'h0000_00AB, 0, 0, 5'd0, 1, 0, 0);
    issue(1, 1, 0, 2'd2, 0, 32'h0000_0102, 0, 0, 1, 5'd12, 0, 0, 0);
    check("mis_err", 32'(wb_addr_err), 32'd1);

    // Asynchronous reset while the access waits for data_ok
    @(negedge clk);
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_mem_size = 2'd2; ex_result = 32'h0000_0100;
    ex_reg_write = 1; ex_write_reg = 5'd3; ex_pc = 32'h1111_0000; ex_inst = 32'h2222_0000;
    bus.data_addr_ok = 1;
    #1 check("rst_pre_req", 32'(bus.data_req), 32'd1);
    @(negedge clk); bus.data_addr_ok = 0;
    #1 check("rst_pre_stall", 32'(mem_stall), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus.data_req), 32'd0);
    check("rst_mid_wb", {wb_valid, wb_reg_write, wb_addr_err, 29'(wb_write_reg)}, 32'd0);
    check("rst_mid_result", wb_result, 32'd0);
    check("rst_mid_pc", wb_pc | wb_inst, 32'd0);
    ex_valid = 0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); bus.data_data_ok = 1; bus.data_rdata = 32'hBAD0BAD0;
    #1;
    check("stray_req", 32'(bus.data_req), 32'd0);
    check("stray_stall", 32'(mem_stall), 32'd0);
    @(negedge clk); bus.data_data_ok = 0;
    issue(1, 1, 0, 2'd2, 0, 32'h0000_0100, 0, 32'h0BADF00D, 1, 5'd4, 0, 0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz[1]) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      issue(logic'($urandom_range(0, 7) != 0), logic'(op == 1), logic'(op == 2), sz,
            logic'($urandom_range(0, 1)), a, $urandom, $urandom, logic'($urandom_range(0, 1)),
            5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
